// File: rtl/ps2_scancode_rx.sv
`default_nettype none
// ============================================================================
// Module      : ps2_scancode_rx
// Description : PS/2 keyboard receiver. Synchronises the asynchronous PS/2
//               clock/data pins, assembles 11-bit frames, checks the start,
//               stop and odd-parity bits, and queues valid scancode bytes in
//               a first-word-fall-through FIFO for the key lookup logic.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk         in   1  system clock, rising edge
//   clrn        in   1  asynchronous active-low reset
//   ps2_clk     in   1  PS/2 clock pin (asynchronous, idle high)
//   ps2_data    in   1  PS/2 data pin (asynchronous, idle high)
//   nextdata_n  in   1  active-low pop, honoured only while ready=1
//   data        out  8  head-of-FIFO scancode byte, valid while ready=1
//   ready       out  1  FIFO non-empty
//   overflow    out  1  sticky: a valid frame was dropped on a full FIFO
//   frame_err   out  1  one-cycle pulse: bad framing/parity or timeout abort
// ============================================================================
module ps2_scancode_rx #(
    parameter int FIFO_AW     = 3,
    parameter int TIMEOUT_CYC = 5000
) (
    input  logic       clk,
    input  logic       clrn,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic       nextdata_n,
    output logic [7:0] data,
    output logic       ready,
    output logic       overflow,
    output logic       frame_err
);

    localparam int c_DEPTH  = 2 ** FIFO_AW;
    localparam int c_IDLE_W = $clog2(TIMEOUT_CYC);
    localparam logic [c_IDLE_W-1:0] c_IDLE_LAST = c_IDLE_W'(TIMEOUT_CYC - 1);
    localparam logic [3:0] c_STOP_IDX = 4'd10;

    // ------------------------------------------------------------------
    // Pin synchronisers. The third clock stage gives a registered "previous"
    // value so a falling edge is seen as s2=1, s1=0.
    // ------------------------------------------------------------------
    logic r_clk_s0, r_clk_s1, r_clk_s2;
    logic r_data_s0, r_data_s1;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_clk_s0  <= 1'b1;
            r_clk_s1  <= 1'b1;
            r_clk_s2  <= 1'b1;
            r_data_s0 <= 1'b1;
            r_data_s1 <= 1'b1;
        end else begin
            r_clk_s0  <= ps2_clk;
            r_clk_s1  <= r_clk_s0;
            r_clk_s2  <= r_clk_s1;
            r_data_s0 <= ps2_data;
            r_data_s1 <= r_data_s0;
        end
    end

    logic w_fall;
    logic w_bit;

    assign w_fall = r_clk_s2 & ~r_clk_s1;
    assign w_bit  = r_data_s1;

    // ------------------------------------------------------------------
    // Frame assembly. r_shift[0] = start, [8:1] = d0..d7, [9] = parity.
    // The stop bit is never stored: it is checked live on its falling edge.
    // ------------------------------------------------------------------
    logic [3:0]          r_bit_cnt;
    logic [9:0]          r_shift;
    logic [c_IDLE_W-1:0] r_idle;
    logic                r_frame_err;

    logic w_stop;
    logic w_frame_ok;
    logic w_push;
    logic w_bad;
    logic w_timeout;

    assign w_stop     = w_fall && (r_bit_cnt == c_STOP_IDX);
    assign w_frame_ok = ~r_shift[0] & w_bit & (^r_shift[9:1]);
    assign w_push     = w_stop & w_frame_ok;
    assign w_bad      = w_stop & ~w_frame_ok;
    // A fall in the same cycle restarts the idle window, so it wins.
    assign w_timeout  = ~w_fall && (r_bit_cnt != 4'd0) && (r_idle == c_IDLE_LAST);

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_bit_cnt   <= 4'd0;
            r_shift     <= 10'd0;
            r_idle      <= '0;
            r_frame_err <= 1'b0;
        end else begin
            r_frame_err <= w_bad | w_timeout;

            if (w_fall) begin
                if (r_bit_cnt == c_STOP_IDX) begin
                    r_bit_cnt <= 4'd0;
                end else begin
                    for (int i = 0; i < 10; i++) begin
                        if (r_bit_cnt == 4'(i)) begin
                            r_shift[i] <= w_bit;
                        end
                    end
                    r_bit_cnt <= r_bit_cnt + 4'd1;
                end
            end else if (w_timeout) begin
                r_bit_cnt <= 4'd0;
            end

            if (w_fall || (r_bit_cnt == 4'd0) || w_timeout) begin
                r_idle <= '0;
            end else begin
                r_idle <= r_idle + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // FWFT FIFO. Pointers carry one extra bit to tell full from empty.
    // A pop frees a slot in the same edge, so a push while full still lands
    // when a pop accompanies it.
    // ------------------------------------------------------------------
    logic [7:0]       r_mem [c_DEPTH];
    logic [FIFO_AW:0] r_wr_ptr;
    logic [FIFO_AW:0] r_rd_ptr;
    logic             r_overflow;

    logic w_empty;
    logic w_full;
    logic w_pop;
    logic w_wr_en;

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[FIFO_AW] != r_rd_ptr[FIFO_AW]) &&
                     (r_wr_ptr[FIFO_AW-1:0] == r_rd_ptr[FIFO_AW-1:0]);
    assign w_pop   = ~nextdata_n & ~w_empty;
    assign w_wr_en = w_push & (~w_full | w_pop);

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            for (int i = 0; i < c_DEPTH; i++) begin
                r_mem[i] <= 8'h00;
            end
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr_en) begin
                r_mem[r_wr_ptr[FIFO_AW-1:0]] <= r_shift[8:1];
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push && w_full && !w_pop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign data      = r_mem[r_rd_ptr[FIFO_AW-1:0]];
    assign ready     = ~w_empty;
    assign overflow  = r_overflow;
    assign frame_err = r_frame_err;

endmodule
`default_nettype wire

// File: tb/tb_ps2_scancode_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_ps2_scancode_rx
// Description : Directed self-checking bench for ps2_scancode_rx. PS/2 frames
//               are bit-banged at a bit period of 2*c_HALF system clocks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ps2_scancode_rx;

    localparam int c_HALF        = 20;
    localparam int c_TIMEOUT_CYC = 5000;

    logic       clk;
    logic       clrn;
    logic       ps2_clk;
    logic       ps2_data;
    logic       nextdata_n;
    logic [7:0] data;
    logic       ready;
    logic       overflow;
    logic       frame_err;

    int n_tests;
    int n_fails;
    int err_cycles;

    ps2_scancode_rx #(
        .FIFO_AW     (3),
        .TIMEOUT_CYC (c_TIMEOUT_CYC)
    ) u_dut (
        .clk        (clk),
        .clrn       (clrn),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .nextdata_n (nextdata_n),
        .data       (data),
        .ready      (ready),
        .overflow   (overflow),
        .frame_err  (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counts every cycle frame_err is high; a clean pulse adds exactly one.
    always @(negedge clk) begin
        if (frame_err === 1'b1) err_cycles++;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic ps2_bit(input logic b);
        @(negedge clk);
        ps2_data = b;
        repeat (c_HALF) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (c_HALF) @(negedge clk);
        ps2_clk = 1'b1;
    endtask

    function automatic logic [10:0] mk_frame(input logic [7:0] b, input logic flip_par);
        logic par;
        par = ~(^b) ^ flip_par;
        return {1'b1, par, b, 1'b0};
    endfunction

    task automatic send_frame(input logic [7:0] b, input logic flip_par);
        logic [10:0] f;
        f = mk_frame(b, flip_par);
        for (int i = 0; i < 11; i++) ps2_bit(f[i]);
        repeat (4) @(negedge clk);
    endtask

    task automatic pop_one();
        @(negedge clk);
        nextdata_n = 1'b0;
        @(negedge clk);
        nextdata_n = 1'b1;
    endtask

    initial begin
        logic [10:0] f;
        int          e0;

        n_tests    = 0;
        n_fails    = 0;
        err_cycles = 0;
        clrn       = 1'b0;
        ps2_clk    = 1'b1;
        ps2_data   = 1'b1;
        nextdata_n = 1'b1;

        repeat (3) @(negedge clk);
        check_val("rst_ready",    32'(ready),     32'd0);
        check_val("rst_overflow", 32'(overflow),  32'd0);
        check_val("rst_frame_err",32'(frame_err), 32'd0);
        check_val("rst_data",     32'(data),      32'h00);
        clrn = 1'b1;
        repeat (3) @(negedge clk);

        // 1: single frame 1C, latency of ready from the stop-bit pin fall
        e0 = err_cycles;
        f  = mk_frame(8'h1C, 1'b0);
        for (int i = 0; i < 10; i++) ps2_bit(f[i]);
        @(negedge clk);
        ps2_data = 1'b1;
        repeat (c_HALF) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (2) @(posedge clk);
        #1 check_val("t1_ready_early", 32'(ready), 32'd0);
        repeat (2) @(posedge clk);
        #1 check_val("t1_ready_4clk", 32'(ready), 32'd1);
        check_val("t1_data", 32'(data), 32'h1C);
        repeat (c_HALF) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (4) @(negedge clk);
        check_val("t1_no_err", 32'(err_cycles - e0), 32'd0);
        pop_one();
        check_val("t1_empty", 32'(ready), 32'd0);

        // 2: three bytes queued, drained in order
        send_frame(8'h1C, 1'b0);
        send_frame(8'hF0, 1'b0);
        send_frame(8'h1C, 1'b0);
        check_val("t2_head0", 32'(data), 32'h1C);
        pop_one();
        check_val("t2_head1", 32'(data), 32'hF0);
        pop_one();
        check_val("t2_head2", 32'(data), 32'h1C);
        check_val("t2_ready", 32'(ready), 32'd1);
        pop_one();
        check_val("t2_drained", 32'(ready), 32'd0);
        pop_one();  // pop while empty is ignored
        check_val("t2_empty_pop", 32'(ready), 32'd0);

        // 3: parity error
        e0 = err_cycles;
        send_frame(8'h1C, 1'b1);
        check_val("t3_err_pulse", 32'(err_cycles - e0), 32'd1);
        check_val("t3_ready", 32'(ready), 32'd0);

        // 4: nine frames into an eight-deep FIFO
        e0 = err_cycles;
        for (int i = 0; i < 8; i++) send_frame(8'(i), 1'b0);
        check_val("t4_no_ovf_at_8", 32'(overflow), 32'd0);
        send_frame(8'h08, 1'b0);
        check_val("t4_overflow", 32'(overflow), 32'd1);
        check_val("t4_no_err", 32'(err_cycles - e0), 32'd0);
        for (int i = 0; i < 8; i++) begin
            check_val($sformatf("t4_drain%0d", i), 32'(data), 32'(i));
            pop_one();
        end
        check_val("t4_empty", 32'(ready), 32'd0);
        check_val("t4_ovf_sticky", 32'(overflow), 32'd1);

        // 5: partial frame abandoned -> timeout, then a clean frame
        e0 = err_cycles;
        f  = mk_frame(8'h5A, 1'b0);
        for (int i = 0; i < 5; i++) ps2_bit(f[i]);
        repeat (c_TIMEOUT_CYC - 200) @(negedge clk);
        check_val("t5_no_err_yet", 32'(err_cycles - e0), 32'd0);
        repeat (400) @(negedge clk);
        check_val("t5_timeout_err", 32'(err_cycles - e0), 32'd1);
        send_frame(8'h5A, 1'b0);
        check_val("t5_ready", 32'(ready), 32'd1);
        check_val("t5_data", 32'(data), 32'h5A);
        check_val("t5_one_err", 32'(err_cycles - e0), 32'd1);
        pop_one();

        // 6: reset mid-frame with three bytes queued
        send_frame(8'h11, 1'b0);
        send_frame(8'h22, 1'b0);
        send_frame(8'h33, 1'b0);
        f = mk_frame(8'hAA, 1'b0);
        for (int i = 0; i < 4; i++) ps2_bit(f[i]);
        @(negedge clk);
        clrn = 1'b0;
        @(negedge clk);
        check_val("t6_ready", 32'(ready), 32'd0);
        check_val("t6_overflow", 32'(overflow), 32'd0);
        check_val("t6_data", 32'(data), 32'h00);
        @(negedge clk);
        clrn = 1'b1;
        repeat (3) @(negedge clk);
        e0 = err_cycles;
        send_frame(8'h29, 1'b0);
        check_val("t6_rx_ready", 32'(ready), 32'd1);
        check_val("t6_rx_data", 32'(data), 32'h29);
        check_val("t6_no_err", 32'(err_cycles - e0), 32'd0);
        pop_one();
        check_val("t6_empty", 32'(ready), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fails);
        $finish;
    end

endmodule
`default_nettype wire
